axi4_lite_gpu_fill: RTL and testbench

AXI4_LITE_GPU_FILL -- requirements
Module: axi4_lite_gpu_fill

---
 rtl/axi4_lite_gpu_fill.sv | 210 +++++++++++++++++++++
 tb/tb_axi4_lite_gpu_fill.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_gpu_fill.sv
// AXI4-Lite controlled rectangle fill engine: software programs two corners and a colour,
// then the engine writes one framebuffer pixel per cycle in row-major order.
module axi4_lite_gpu_fill #(
  parameter int FRAME_WIDTH_SCALED  = 640,
  parameter int FRAME_HEIGHT_SCALED = 480,
  parameter int AXI_ADDRESS_WIDTH   = 32,
  parameter int AXI_DATA_WIDTH      = 32,
  parameter int FBUF_ADDR_WIDTH     = 19,
  parameter int FBUF_DATA_WIDTH     = 8
) (
  input  logic                         s_axi_ctrl_aclk,
  input  logic                         s_axi_ctrl_aresetn,
  input  logic [AXI_ADDRESS_WIDTH-1:0] s_axi_ctrl_araddr,
  input  logic                         s_axi_ctrl_arvalid,
  output logic                         s_axi_ctrl_arready,
  output logic [AXI_DATA_WIDTH-1:0]    s_axi_ctrl_rdata,
  output logic [1:0]                   s_axi_ctrl_rresp,
  output logic                         s_axi_ctrl_rvalid,
  input  logic                         s_axi_ctrl_rready,
  input  logic [AXI_ADDRESS_WIDTH-1:0] s_axi_ctrl_awaddr,
  input  logic                         s_axi_ctrl_awvalid,
  output logic                         s_axi_ctrl_awready,
  input  logic [AXI_DATA_WIDTH-1:0]    s_axi_ctrl_wdata,
  input  logic [3:0]                   s_axi_ctrl_wstrb,
  input  logic                         s_axi_ctrl_wvalid,
  output logic                         s_axi_ctrl_wready,
  output logic [1:0]                   s_axi_ctrl_bresp,
  output logic                         s_axi_ctrl_bvalid,
  input  logic                         s_axi_ctrl_bready,
  output logic                         fbuf_en_wr,
  output logic                         fbuf_wrea,
  output logic [FBUF_ADDR_WIDTH-1:0]   fbuf_addr,
  output logic [FBUF_DATA_WIDTH-1:0]   fbuf_data
);
  localparam int DW = AXI_DATA_WIDTH;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Handshakes: a beat transfers on a rising edge where valid and ready are both high.
  typedef enum logic {IDLE, FILL} state_t;
  state_t state_q, state_d;

  logic [DW-1:0] p0, p1, color, pixcnt;
  logic          err;
  logic          aw_held, w_held;
  logic [7:0]    aw_off;
  logic [DW-1:0] w_data;
  logic [3:0]    w_strb;
  logic [15:0]   sx0, sx1, sy1, cur_x, cur_y;
  logic [FBUF_DATA_WIDTH-1:0] col_snap;

  logic busy, wr_exec, last_pix, start_go;
  logic wr_err, wr_p0, wr_p1, wr_col, start_fill, start_pix, err_set, err_clr;
  logic rd_err;
  logic [DW-1:0] rd_data;
  logic rect_ok, pt_ok;
  logic addr_unused;

  assign addr_unused = ^{s_axi_ctrl_araddr[AXI_ADDRESS_WIDTH-1:8],
                         s_axi_ctrl_awaddr[AXI_ADDRESS_WIDTH-1:8]};

  assign busy     = (state_q == FILL);
  assign wr_exec  = aw_held & w_held & ~s_axi_ctrl_bvalid;
  assign last_pix = (cur_x == sx1) && (cur_y == sy1);
  assign start_go = wr_exec & (start_fill | start_pix);

  assign s_axi_ctrl_arready = s_axi_ctrl_aresetn & ~s_axi_ctrl_rvalid;
  assign s_axi_ctrl_awready = s_axi_ctrl_aresetn & ~aw_held & ~s_axi_ctrl_bvalid;
  assign s_axi_ctrl_wready  = s_axi_ctrl_aresetn & ~w_held & ~s_axi_ctrl_bvalid;

  assign fbuf_en_wr = busy;
  assign fbuf_wrea  = busy;
  assign fbuf_addr  = busy ? FBUF_ADDR_WIDTH'(32'(cur_y) * 32'(FRAME_WIDTH_SCALED) + 32'(cur_x))
                           : '0;
  assign fbuf_data  = busy ? col_snap : '0;

  assign pt_ok   = (32'(p0[15:0]) < 32'(FRAME_WIDTH_SCALED)) &&
                   (32'(p0[31:16]) < 32'(FRAME_HEIGHT_SCALED));
  assign rect_ok = (p0[15:0] <= p1[15:0]) && (p0[31:16] <= p1[31:16]) &&
                   (32'(p1[15:0]) < 32'(FRAME_WIDTH_SCALED)) &&
                   (32'(p1[31:16]) < 32'(FRAME_HEIGHT_SCALED));

  function automatic logic [DW-1:0] strb_merge(input logic [DW-1:0] old_v,
                                               input logic [DW-1:0] new_v,
                                               input logic [3:0] strb);
    logic [DW-1:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++)
      if (strb[i]) res[i*8 +: 8] = new_v[i*8 +: 8];
    return res;
  endfunction

  always_comb begin
    wr_err = 1'b0; wr_p0 = 1'b0; wr_p1 = 1'b0; wr_col = 1'b0;
    start_fill = 1'b0; start_pix = 1'b0; err_set = 1'b0; err_clr = 1'b0;
    case (aw_off)
      8'h00: begin
        if (busy) wr_err = 1'b1;
        else if (w_strb[0]) begin
          err_clr = w_data[2];
          if (w_data[0]) begin
            if (rect_ok) start_fill = 1'b1;
            else begin wr_err = 1'b1; err_set = 1'b1; end
          end else if (w_data[1]) begin
            if (pt_ok) start_pix = 1'b1;
            else begin wr_err = 1'b1; err_set = 1'b1; end
          end
        end
      end
      8'h08:   if (busy) wr_err = 1'b1; else wr_p0  = 1'b1;
      8'h0C:   if (busy) wr_err = 1'b1; else wr_p1  = 1'b1;
      8'h10:   if (busy) wr_err = 1'b1; else wr_col = 1'b1;
      default: wr_err = 1'b1;
    endcase
  end

  always_comb begin
    rd_err  = 1'b0;
    rd_data = '0;
    case (s_axi_ctrl_araddr[7:0])
      8'h04:   rd_data = {{(DW-2){1'b0}}, err, busy};
      8'h08:   rd_data = p0;
      8'h0C:   rd_data = p1;
      8'h10:   rd_data = color;
      8'h14:   rd_data = pixcnt;
      default: rd_err  = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_go) state_d = FILL;
      FILL:    if (last_pix) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge s_axi_ctrl_aclk or negedge s_axi_ctrl_aresetn) begin
    if (!s_axi_ctrl_aresetn) state_q <= IDLE;
    else                     state_q <= state_d;
  end

  always_ff @(posedge s_axi_ctrl_aclk or negedge s_axi_ctrl_aresetn) begin
    if (!s_axi_ctrl_aresetn) begin
      aw_held <= 1'b0; w_held <= 1'b0; aw_off <= '0; w_data <= '0; w_strb <= '0;
      s_axi_ctrl_bvalid <= 1'b0; s_axi_ctrl_bresp <= RESP_OKAY;
      p0 <= '0; p1 <= '0; color <= '0; err <= 1'b0;
    end else begin
      if (s_axi_ctrl_awvalid && s_axi_ctrl_awready) begin
        aw_held <= 1'b1;
        aw_off  <= s_axi_ctrl_awaddr[7:0];
      end
      if (s_axi_ctrl_wvalid && s_axi_ctrl_wready) begin
        w_held <= 1'b1;
        w_data <= s_axi_ctrl_wdata;
        w_strb <= s_axi_ctrl_wstrb;
      end
      if (wr_exec) begin
        s_axi_ctrl_bvalid <= 1'b1;
        s_axi_ctrl_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
        if (wr_p0)  p0    <= strb_merge(p0, w_data, w_strb);
        if (wr_p1)  p1    <= strb_merge(p1, w_data, w_strb);
        if (wr_col) color <= strb_merge(color, w_data, w_strb);
        if (err_set)      err <= 1'b1;
        else if (err_clr) err <= 1'b0;
      end else if (s_axi_ctrl_bvalid && s_axi_ctrl_bready) begin
        s_axi_ctrl_bvalid <= 1'b0;
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
    end
  end

  always_ff @(posedge s_axi_ctrl_aclk or negedge s_axi_ctrl_aresetn) begin
    if (!s_axi_ctrl_aresetn) begin
      s_axi_ctrl_rvalid <= 1'b0; s_axi_ctrl_rdata <= '0; s_axi_ctrl_rresp <= RESP_OKAY;
    end else if (s_axi_ctrl_arvalid && s_axi_ctrl_arready) begin
      s_axi_ctrl_rvalid <= 1'b1;
      s_axi_ctrl_rdata  <= rd_err ? '0 : rd_data;
      s_axi_ctrl_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
    end else if (s_axi_ctrl_rvalid && s_axi_ctrl_rready) begin
      s_axi_ctrl_rvalid <= 1'b0;
    end
  end

  // A single-pixel write runs as a 1x1 fill so both paths share the pixel datapath.
  always_ff @(posedge s_axi_ctrl_aclk or negedge s_axi_ctrl_aresetn) begin
    if (!s_axi_ctrl_aresetn) begin
      sx0 <= '0; sx1 <= '0; sy1 <= '0; cur_x <= '0; cur_y <= '0;
      col_snap <= '0; pixcnt <= '0;
    end else if (start_go) begin
      sx0      <= p0[15:0];
      sx1      <= start_fill ? p1[15:0]  : p0[15:0];
      sy1      <= start_fill ? p1[31:16] : p0[31:16];
      cur_x    <= p0[15:0];
      cur_y    <= p0[31:16];
      col_snap <= color[FBUF_DATA_WIDTH-1:0];
      pixcnt   <= '0;
    end else if (busy) begin
      if (pixcnt != '1) pixcnt <= pixcnt + 32'd1;
      if (cur_x == sx1) begin
        cur_x <= sx0;
        if (!last_pix) cur_y <= cur_y + 16'd1;
      end else begin
        cur_x <= cur_x + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_axi4_lite_gpu_fill.sv
// Bench for axi4_lite_gpu_fill: register access, fills, error paths and reset abort;
// framebuffer writes are checked against a queue of expected {addr, data} pixels.
module tb_axi4_lite_gpu_fill;
  localparam int FW = 640;
  localparam logic [31:0] A_CTRL = 32'h00, A_STATUS = 32'h04, A_P0 = 32'h08,
                          A_P1 = 32'h0C, A_COLOR = 32'h10, A_PIXCNT = 32'h14;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
  logic        arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0;
  logic        rready = 1'b1, bready = 1'b1;
  logic [3:0]  wstrb = '0;
  logic        arready, awready, wready, rvalid, bvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;
  logic        fbuf_en_wr, fbuf_wrea;
  logic [18:0] fbuf_addr;
  logic [7:0]  fbuf_data;

  int errors = 0;
  int checks = 0;
  bit ignore_pix = 1'b0;
  logic [31:0] exp_q[$];

  axi4_lite_gpu_fill dut (
    .s_axi_ctrl_aclk(clk), .s_axi_ctrl_aresetn(rst_n),
    .s_axi_ctrl_araddr(araddr), .s_axi_ctrl_arvalid(arvalid), .s_axi_ctrl_arready(arready),
    .s_axi_ctrl_rdata(rdata), .s_axi_ctrl_rresp(rresp), .s_axi_ctrl_rvalid(rvalid),
    .s_axi_ctrl_rready(rready),
    .s_axi_ctrl_awaddr(awaddr), .s_axi_ctrl_awvalid(awvalid), .s_axi_ctrl_awready(awready),
    .s_axi_ctrl_wdata(wdata), .s_axi_ctrl_wstrb(wstrb), .s_axi_ctrl_wvalid(wvalid),
    .s_axi_ctrl_wready(wready),
    .s_axi_ctrl_bresp(bresp), .s_axi_ctrl_bvalid(bvalid), .s_axi_ctrl_bready(bready),
    .fbuf_en_wr(fbuf_en_wr), .fbuf_wrea(fbuf_wrea), .fbuf_addr(fbuf_addr), .fbuf_data(fbuf_data)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pix(input int x, input int y, input logic [7:0] col);
    logic [18:0] a;
    a = 19'(y * FW + x);
    return {5'b0, a, col};
  endfunction

  // scoreboard: every framebuffer write must match the oldest expected pixel
  always @(negedge clk) begin
    if (rst_n && fbuf_en_wr && !ignore_pix) begin
      check("fbuf_wrea", 64'(fbuf_wrea), 64'd1);
      if (exp_q.size() == 0) check("fbuf_unexpected_pixel", 64'({5'b0, fbuf_addr, fbuf_data}), 64'hFFFF_FFFF);
      else check("fbuf_pixel", 64'({5'b0, fbuf_addr, fbuf_data}), 64'(exp_q.pop_front()));
    end
  end

  // driver tasks
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_lead, output logic [1:0] resp);
    bit aw_done, w_done, aw_hs, w_hs;
    int n;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb; wvalid = 1'b1;
    while (!(aw_done && w_done) && n < 200) begin
      if (!aw_done && n >= w_lead) awvalid = 1'b1;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_hs) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (w_hs)  begin wvalid  = 1'b0; w_done  = 1'b1; end
      n++;
      @(negedge clk);
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_done && w_done)) begin
      check("aw_w_timeout", 64'd0, 64'd1);
      resp = 2'b11;
      return;
    end
    n = 0;
    while (!bvalid && n < 200) begin @(negedge clk); n++; end
    if (!bvalid) begin
      check("b_timeout", 64'd0, 64'd1);
      resp = 2'b11;
      return;
    end
    resp = bresp;
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit ar_hs, done;
    int n;
    done = 1'b0; n = 0;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1;
    while (!done && n < 200) begin
      ar_hs = arvalid && arready;
      @(posedge clk); #1;
      if (ar_hs) begin arvalid = 1'b0; done = 1'b1; end
      n++;
      @(negedge clk);
    end
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 200) begin @(negedge clk); n++; end
    if (!done || !rvalid) begin
      check("r_timeout", 64'd0, 64'd1);
      data = '0; resp = 2'b11;
      return;
    end
    data = rdata;
    resp = rresp;
    @(posedge clk); #1;
  endtask

  task automatic wr_chk(input string tag, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [1:0] exp_resp);
    logic [1:0] r;
    axi_write(addr, data, strb, 0, r);
    check(tag, 64'(r), 64'(exp_resp));
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                        input logic [1:0] exp_resp);
    logic [31:0] d;
    logic [1:0] r;
    axi_read(addr, d, r);
    check({tag, "_resp"}, 64'(r), 64'(exp_resp));
    check(tag, 64'(d), 64'(exp_data));
  endtask

  task automatic wait_idle();
    logic [31:0] d;
    logic [1:0] r;
    int n;
    n = 0;
    do begin
      axi_read(A_STATUS, d, r);
      n++;
    end while (d[0] && n < 200);
    check("wait_idle", 64'(d[0]), 64'd0);
  endtask

  initial begin
    logic [1:0] r;
    logic [31:0] d;
    #12;
    check("rst_arready", 64'(arready), 64'd0);
    check("rst_awready", 64'(awready), 64'd0);
    check("rst_wready", 64'(wready), 64'd0);
    check("rst_bvalid_rvalid", 64'({bvalid, rvalid}), 64'd0);
    check("rst_fbuf", 64'({fbuf_en_wr, fbuf_wrea, fbuf_addr, fbuf_data}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 64'({arready, awready, wready}), 64'h7);
    rd_chk("rst_status", A_STATUS, 32'h0, 2'b00);
    rd_chk("rst_pixcnt", A_PIXCNT, 32'h0, 2'b00);

    // basic 2x2 fill
    wr_chk("p0_wr", A_P0, 32'h0001_0002, 4'hF, 2'b00);
    wr_chk("p1_wr", A_P1, 32'h0002_0003, 4'hF, 2'b00);
    wr_chk("col_wr", A_COLOR, 32'h0000_00AB, 4'hF, 2'b00);
    for (int y = 1; y <= 2; y++)
      for (int x = 2; x <= 3; x++) exp_q.push_back(pix(x, y, 8'hAB));
    check("fill_addr0", 64'(exp_q[0][26:8]), 64'd642);
    wr_chk("fill_ctrl", A_CTRL, 32'h1, 4'hF, 2'b00);
    wait_idle();
    check("fill_drained", 64'(exp_q.size()), 64'd0);
    rd_chk("fill_pixcnt", A_PIXCNT, 32'd4, 2'b00);

    // W leads AW by three cycles
    axi_write(A_COLOR, 32'h0000_005A, 4'hF, 3, r);
    check("wlead_resp", 64'(r), 64'd0);
    @(negedge clk);
    check("wlead_single_b", 64'(bvalid), 64'd0);
    rd_chk("wlead_color", A_COLOR, 32'h5A, 2'b00);

    // invalid rectangle then error clear
    wr_chk("inv_p0", A_P0, 32'h0000_0005, 4'hF, 2'b00);
    wr_chk("inv_p1", A_P1, 32'h0000_0004, 4'hF, 2'b00);
    wr_chk("inv_ctrl", A_CTRL, 32'h1, 4'hF, 2'b10);
    rd_chk("inv_status", A_STATUS, 32'h2, 2'b00);
    wr_chk("clr_ctrl", A_CTRL, 32'h4, 4'hF, 2'b00);
    rd_chk("clr_status", A_STATUS, 32'h0, 2'b00);

    // busy: 100x4 fill, writes refused, reads served
    wr_chk("busy_p0", A_P0, 32'h000A_0005, 4'hF, 2'b00);
    wr_chk("busy_p1", A_P1, 32'h000D_0068, 4'hF, 2'b00);
    for (int y = 10; y <= 13; y++)
      for (int x = 5; x <= 104; x++) exp_q.push_back(pix(x, y, 8'h5A));
    wr_chk("busy_ctrl", A_CTRL, 32'h1, 4'hF, 2'b00);
    wr_chk("busy_p0_refused", A_P0, 32'h0000_1234, 4'hF, 2'b10);
    rd_chk("busy_status", A_STATUS, 32'h1, 2'b00);
    wait_idle();
    rd_chk("busy_p0_kept", A_P0, 32'h000A_0005, 2'b00);
    rd_chk("busy_pixcnt", A_PIXCNT, 32'd400, 2'b00);
    check("busy_drained", 64'(exp_q.size()), 64'd0);

    // strobes, unmapped and wrong-direction accesses, single pixel
    wr_chk("strb_p0_zero", A_P0, 32'h0, 4'hF, 2'b00);
    wr_chk("strb_p0", A_P0, 32'hFFFF_FFFF, 4'b0001, 2'b00);
    rd_chk("strb_p0_rd", A_P0, 32'hFF, 2'b00);
    rd_chk("unmapped_rd", 32'h40, 32'h0, 2'b10);
    rd_chk("ctrl_rd", A_CTRL, 32'h0, 2'b10);
    wr_chk("status_wr", A_STATUS, 32'h1, 4'hF, 2'b10);
    wr_chk("ctrl_nostrb", A_CTRL, 32'h1, 4'b0010, 2'b00);
    rd_chk("ctrl_nostrb_status", A_STATUS, 32'h0, 2'b00);
    exp_q.push_back(pix(255, 0, 8'h5A));
    wr_chk("single_ctrl", A_CTRL, 32'h2, 4'hF, 2'b00);
    wait_idle();
    rd_chk("single_pixcnt", A_PIXCNT, 32'd1, 2'b00);
    wr_chk("oof_p0", A_P0, 32'h0000_0280, 4'hF, 2'b00);
    wr_chk("oof_ctrl", A_CTRL, 32'h2, 4'hF, 2'b10);
    rd_chk("oof_status", A_STATUS, 32'h2, 2'b00);
    wr_chk("oof_clr", A_CTRL, 32'h4, 4'hF, 2'b00);

    // random colour/rectangle fills
    for (int t = 0; t < 3; t++) begin
      int x0, y0, w, h;
      logic [7:0] c;
      x0 = $urandom_range(630, 0); y0 = $urandom_range(470, 0);
      w = $urandom_range(9, 0); h = $urandom_range(3, 0);
      c = 8'($urandom_range(255, 0));
      wr_chk("rnd_p0", A_P0, {16'(y0), 16'(x0)}, 4'hF, 2'b00);
      wr_chk("rnd_p1", A_P1, {16'(y0 + h), 16'(x0 + w)}, 4'hF, 2'b00);
      wr_chk("rnd_col", A_COLOR, {24'hABCDEF, c}, 4'hF, 2'b00);
      for (int y = y0; y <= y0 + h; y++)
        for (int x = x0; x <= x0 + w; x++) exp_q.push_back(pix(x, y, c));
      wr_chk("rnd_ctrl", A_CTRL, 32'h1, 4'hF, 2'b00);
      wait_idle();
      rd_chk("rnd_pixcnt", A_PIXCNT, 32'((w + 1) * (h + 1)), 2'b00);
    end
    check("rnd_drained", 64'(exp_q.size()), 64'd0);

    // reset during a full-frame fill
    wr_chk("rst_p0", A_P0, 32'h0, 4'hF, 2'b00);
    wr_chk("rst_p1", A_P1, 32'h01DF_027F, 4'hF, 2'b00);
    ignore_pix = 1'b1;
    wr_chk("rst_ctrl", A_CTRL, 32'h1, 4'hF, 2'b00);
    repeat (20) @(negedge clk);
    check("rst_pre_busy", 64'(fbuf_en_wr), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_fbuf_en", 64'({fbuf_en_wr, fbuf_wrea}), 64'd0);
    check("rst_mid_ready", 64'({arready, awready, wready}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ignore_pix = 1'b0;
    rd_chk("rst_after_status", A_STATUS, 32'h0, 2'b00);
    rd_chk("rst_after_pixcnt", A_PIXCNT, 32'h0, 2'b00);
    rd_chk("rst_after_p1", A_P1, 32'h0, 2'b00);
    repeat (5) @(negedge clk);
    axi_read(A_COLOR, d, r);
    check("rst_after_color", 64'({r, d}), 64'd0);
    check("final_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule
